flip_flop_fifo_with_counter: RTL and testbench

FLIP_FLOP_FIFO_WITH_COUNTER -- requirements
Module: flip_flop_fifo_with_counter

---
 rtl/flip_flop_fifo_with_counter.sv | 97 +++++++++
 tb/tb_flip_flop_fifo_with_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/flip_flop_fifo_with_counter.sv
// flip_flop_fifo_with_counter
//   Synchronous FIFO with storage in a flip-flop array. It keeps a write pointer,
//   a read pointer and an occupancy counter. Pointers wrap by explicit compare,
//   so any depth >= 2 is legal, including depths that are not powers of two.
//   read_data is a combinational read of the head entry, so it has zero read latency.
//
// Ports
//   clk        : single clock; all state updates occur on its rising edge
//   rst        : asynchronous active-high reset (pointers and counter only)
//   push       : write request for this cycle
//   pop        : read request for this cycle
//   write_data : data stored when a push is accepted
//   read_data  : oldest stored entry (unspecified while empty)
//   empty      : occupancy == 0
//   full       : occupancy == depth
//
// Handshake: a pop is accepted when pop && !empty. A push is accepted when
// push && (!full || pop). When the FIFO is full, a push paired with a pop is
// legal because the pop frees the head slot on the same edge. Requests that
// are not accepted leave all state unchanged.
module flip_flop_fifo_with_counter #(
  parameter int width = 8,
  parameter int depth = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] write_data,
  output logic [width-1:0] read_data,
  output logic             empty,
  output logic             full
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(depth);

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_acc;
  logic             pop_acc;

  // Flags come from the counter alone, never from pointer comparison.
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop);

  assign read_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_acc) begin
      mem_d[wr_ptr_q] = write_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    // When a push and a pop are both accepted, occupancy does not change.
    if (push_acc && !pop_acc) begin
      count_d = count_q + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_flip_flop_fifo_with_counter.sv
// Testbench for flip_flop_fifo_with_counter (width=8, depth=5).
// A queue-based reference model decides which requests are accepted. On each
// accepted pop, the model head is pushed to exp_q. A separate monitor pops
// exp_q whenever the DUT presents a pop with empty low, and compares read_data.
module tb_flip_flop_fifo_with_counter;

  localparam int W = 8;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         push;
  logic         pop;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data;
  logic         empty;
  logic         full;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];

  flip_flop_fifo_with_counter #(.width(W), .depth(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .write_data (write_data),
    .read_data  (read_data),
    .empty      (empty),
    .full       (full)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: checks the flags against the model, applies one cycle of requests,
  // and advances the model.
  task automatic cycle(input logic p, input logic q, input logic [W-1:0] d);
    int sz;
    @(negedge clk);
    #1;
    sz = model_q.size();
    chk("empty_flag", {31'b0, empty}, {31'b0, sz == 0});
    chk("full_flag",  {31'b0, full},  {31'b0, sz == D});
    push       = p;
    pop        = q;
    write_data = d;
    if (q && sz > 0) exp_q.push_back(model_q.pop_front());
    if (p && (sz < D || q)) model_q.push_back(d);
  endtask

  // Monitor: samples after the drive and before the next active edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && pop && !empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h expected no accepted pop", read_data);
        end else begin
          chk("read_data", {24'b0, read_data}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; write_data = '0;
    #12;
    chk("reset_empty", {31'b0, empty}, 32'd1);
    chk("reset_full",  {31'b0, full},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // fill and empty
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'(i * 8'h11));
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // back-to-back simultaneous push and pop across pointer wraps
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, W'((i % 5) * 8'h11));
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // push+pop when full; 0xAB must come out fifth
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'($urandom_range(0, 255)));
    cycle(1'b1, 1'b1, 8'hAB);
    // push at full without pop is ignored
    cycle(1'b1, 1'b0, 8'hEE);
    cycle(1'b1, 1'b0, 8'hEF);
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, '0);
    // pop at empty is ignored
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    // push with pop at empty: push accepted, pop ignored
    cycle(1'b1, 1'b1, 8'h77);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // asynchronous reset with three entries stored
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, W'(8'hC0 + i));
    cycle(1'b0, 1'b0, '0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_empty", {31'b0, empty}, 32'd1);
    chk("midreset_full",  {31'b0, full},  32'd0);
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 8'h5A);
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);

    // randomized traffic
    for (int i = 0; i < 100; i++) begin
      logic p, q;
      p = ($urandom_range(0, 99) < 60);
      q = ($urandom_range(0, 99) < 50);
      if (model_q.size() == D && p) q = ($urandom_range(0, 99) < 40);
      cycle(p, q, W'($urandom_range(0, 255)));
    end
    while (model_q.size() > 0) cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
